// File: rtl/ssm_fp16_pkg.sv
// ssm_fp16_pkg: FP16 constants, lane indexing and exact round-to-nearest-even FP16 arithmetic
package ssm_fp16_pkg;
  localparam int DW = 16;
  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE = 16'h3C00;
  localparam logic [15:0] FP16_HALF = 16'h3800;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  function automatic int lane_idx(input int h, input int p, input int p_tile);
    return h * p_tile + p;
  endfunction
  function automatic int eff_exp(input logic [15:0] a);
    return (|a[14:10]) ? int'(a[14:10]) : 1;
  endfunction
  function automatic logic is_nan(input logic [15:0] a);
    return (&a[14:10]) && (|a[9:0]);
  endfunction
  function automatic logic is_inf(input logic [15:0] a);
    return (&a[14:10]) && !(|a[9:0]);
  endfunction
  // Rounds the exact value m * 2^e to FP16; subnormals fall out of clamping the exponent at 1.
  function automatic logic [15:0] fp16_pack(input logic s, input int e, input logic [47:0] m);
    int l, be, sh, r;
    logic [95:0] t;
    l = 0;
    for (int i = 0; i < 48; i++) if (m[i]) l = i;
    be = l + e + 15;
    if (be < 1) be = 1;
    sh = be - 25 - e;
    t = (sh <= 0) ? {m << (-sh), 48'b0} : ({m, 48'b0} >> ((sh > 49) ? 49 : sh));
    r = int'(t[59:48]) + int'(t[47] & ((|t[46:0]) | t[48]));
    r = ((be - 1) << 10) + r;
    if (m == '0) r = 0;
    else if (r > 31744) r = 31744;
    return {s, r[14:0]};
  endfunction
  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic s;
    logic [21:0] pm;
    s = a[15] ^ b[15];
    pm = {|a[14:10], a[9:0]} * {|b[14:10], b[9:0]};
    if (is_nan(a) || is_nan(b) || (is_inf(a) && !(|b[14:0])) || (is_inf(b) && !(|a[14:0]))) return FP16_QNAN;
    if (is_inf(a) || is_inf(b)) return {s, 15'h7C00};
    return fp16_pack(s, eff_exp(a) + eff_exp(b) - 50, {26'b0, pm});
  endfunction
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, emin;
    logic [47:0] xa, xb, m;
    logic s;
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && a[15] != b[15])) return FP16_QNAN;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    ea = eff_exp(a);
    eb = eff_exp(b);
    emin = (ea < eb) ? ea : eb;
    xa = {37'b0, |a[14:10], a[9:0]} << (ea - emin);
    xb = {37'b0, |b[14:10], b[9:0]} << (eb - emin);
    if (a[15] == b[15]) begin
      m = xa + xb;
      s = a[15];
    end else if (xa >= xb) begin
      m = xa - xb;
      s = (xa == xb) ? 1'b0 : a[15];
    end else begin
      m = xb - xa;
      s = b[15];
    end
    return fp16_pack(s, emin - 25, m);
  endfunction
endpackage

// File: rtl/ssm_y_skip_add_if.sv
// ssm_y_skip_add_if: x/D issue, accumulator sum input and y result bundle
interface ssm_y_skip_add_if import ssm_fp16_pkg::*; #(
  parameter int H_TILE = 1,
  parameter int P_TILE = 1,
  parameter int DEPTH = 4
);
  localparam int W = H_TILE * P_TILE * DW;
  logic x_valid_i;
  logic x_ready_o;
  logic [W-1:0] x_i;
  logic [H_TILE*DW-1:0] D_i;
  logic sum_valid_i;
  logic [W-1:0] sum_hp_i;
  logic y_valid_o;
  logic [W-1:0] y_o;
  logic err_underflow_o;
  logic [$clog2(DEPTH):0] fifo_count_o;
  modport master (
    output x_valid_i, x_i, D_i, sum_valid_i, sum_hp_i,
    input x_ready_o, y_valid_o, y_o, err_underflow_o, fifo_count_o
  );
  modport slave (
    input x_valid_i, x_i, D_i, sum_valid_i, sum_hp_i,
    output x_ready_o, y_valid_o, y_o, err_underflow_o, fifo_count_o
  );
endinterface

// File: rtl/fp16_add_wrapper.sv
// fp16_add_wrapper: FP16 add with a fixed LAT-cycle pipeline
module fp16_add_wrapper import ssm_fp16_pkg::*; #(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);
  logic [DW-1:0] pipe [LAT];
  always_ff @(posedge clk) begin
    pipe[0] <= fp16_add(a, b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign y = pipe[LAT-1];
endmodule

// File: rtl/fp16_mul_wrapper.sv
// fp16_mul_wrapper: FP16 multiply with a fixed LAT-cycle pipeline
module fp16_mul_wrapper import ssm_fp16_pkg::*; #(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);
  logic [DW-1:0] pipe [LAT];
  always_ff @(posedge clk) begin
    pipe[0] <= fp16_mul(a, b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign y = pipe[LAT-1];
endmodule

// File: rtl/ssm_tile_fifo.sv
// ssm_tile_fifo: synchronous FIFO; head read from storage, a pushed word is visible the cycle after
module ssm_tile_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [WIDTH-1:0] wdata,
  input  logic pop,
  output logic [WIDTH-1:0] rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk) if (push) mem[wp] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign rdata = mem[rp];
endmodule

// File: rtl/ssm_y_skip_add.sv
// ssm_y_skip_add: y = sum_hp + D*x, with D*x computed at x issue and parked in a FIFO until its sum arrives
module ssm_y_skip_add import ssm_fp16_pkg::*; #(
  parameter int H_TILE = 1,
  parameter int P_TILE = 1,
  parameter int DEPTH = 4,
  parameter int MUL_LAT = 4,
  parameter int ADD_LAT = 4
) (
  input logic clk,
  input logic rst,
  ssm_y_skip_add_if.slave bus
);
  localparam int LANES = H_TILE * P_TILE;
  localparam int W = LANES * DW;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [MUL_LAT-1:0] mv;
  logic [ADD_LAT-1:0] av;
  logic [W-1:0] prod, head, sum_y, y_hold;
  logic [CW-1:0] count, inflight;
  logic accept, pop, ready, err;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MUL_LAT; i++) inflight = inflight + CW'(mv[i]);
  end
  // Products still in the multiplier already own a FIFO slot, so a push can never overflow.
  assign ready = (32'(count) + 32'(inflight)) < 32'(DEPTH);
  assign accept = bus.x_valid_i && ready;
  assign pop = bus.sum_valid_i && count != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      mv <= '0;
      av <= '0;
      err <= 1'b0;
      y_hold <= {LANES{FP16_ZERO}};
    end else begin
      mv <= MUL_LAT'({mv, accept});
      av <= ADD_LAT'({av, pop});
      if (bus.sum_valid_i && count == '0) err <= 1'b1;
      if (av[ADD_LAT-1]) y_hold <= sum_y;
    end
  end
  ssm_tile_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(mv[MUL_LAT-1]), .wdata(prod),
    .pop(pop), .rdata(head), .count(count)
  );
  for (genvar h = 0; h < H_TILE; h++) begin : g_h
    for (genvar p = 0; p < P_TILE; p++) begin : g_p
      localparam int L = lane_idx(h, p, P_TILE);
      fp16_mul_wrapper #(.LAT(MUL_LAT)) u_mul (
        .clk(clk), .a(bus.D_i[h*DW +: DW]), .b(bus.x_i[L*DW +: DW]), .y(prod[L*DW +: DW])
      );
      fp16_add_wrapper #(.LAT(ADD_LAT)) u_add (
        .clk(clk), .a(head[L*DW +: DW]), .b(bus.sum_hp_i[L*DW +: DW]), .y(sum_y[L*DW +: DW])
      );
    end
  end
  assign bus.x_ready_o = ready;
  assign bus.y_valid_o = av[ADD_LAT-1];
  assign bus.y_o = av[ADD_LAT-1] ? sum_y : y_hold;
  assign bus.err_underflow_o = err;
  assign bus.fifo_count_o = count;
endmodule
